// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage, carry rippling stage to stage.
// Define PIPELINED_ADDER_SAT_EN to saturate the final sum (unsigned) at the last stage.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic             io_carry_in,
  input  logic             io_sub,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_sum,
  output logic             io_carry_out,
  output logic             io_overflow
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign adv         = !io_out_valid || io_out_ready;
  assign io_in_ready = adv;
  assign b_eff       = io_sub ? ~io_in_b : io_in_b;
  assign cin0        = io_sub ? 1'b1 : io_carry_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int OPW  = WIDTH - k * CHUNK;
    localparam int SUMW = (k + 1) * CHUNK;

    logic             valid_in;
    logic             carry_in_s;
    logic [OPW-1:0]   a_in;
    logic [OPW-1:0]   b_in;
    logic [CHUNK:0]   slice;
    logic [SUMW-1:0]  sum_next;
    logic [SUMW-1:0]  sum_load;
    logic             valid_q;
    logic             carry_q;
    logic [SUMW-1:0]  sum_q;
`ifdef PIPELINED_ADDER_SAT_EN
    logic             sub_in;
`endif

    if (k == 0) begin : g_first
      assign valid_in   = io_in_valid;
      assign carry_in_s = cin0;
      assign a_in       = io_in_a;
      assign b_in       = b_eff;
      assign sum_next   = slice[CHUNK-1:0];
`ifdef PIPELINED_ADDER_SAT_EN
      assign sub_in     = io_sub;
`endif
    end else begin : g_next
      // Operands arrive skewed: only the not-yet-added upper slices travel on.
      assign valid_in   = g_stage[k-1].valid_q;
      assign carry_in_s = g_stage[k-1].carry_q;
      assign a_in       = g_stage[k-1].g_ops.a_q;
      assign b_in       = g_stage[k-1].g_ops.b_q;
      assign sum_next   = {slice[CHUNK-1:0], g_stage[k-1].sum_q};
`ifdef PIPELINED_ADDER_SAT_EN
      assign sub_in     = g_stage[k-1].g_ops.sub_q;
`endif
    end

    assign slice = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_in_s};

    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= valid_in;
        carry_q <= slice[CHUNK];
        sum_q   <= sum_load;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [OPW-CHUNK-1:0] a_q;
      logic [OPW-CHUNK-1:0] b_q;
`ifdef PIPELINED_ADDER_SAT_EN
      logic                 sub_q;

      always_ff @(posedge clock) begin
        if (reset) sub_q <= 1'b0;
        else if (adv) sub_q <= sub_in;
      end
`endif

      always_ff @(posedge clock) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[OPW-1:CHUNK];
          b_q <= b_in[OPW-1:CHUNK];
        end
      end

      assign sum_load = sum_next;
    end else begin : g_last
      logic overflow_q;
      logic overflow_next;

      assign overflow_next = (a_in[OPW-1] == b_in[OPW-1]) && (sum_next[SUMW-1] != a_in[OPW-1]);

`ifdef PIPELINED_ADDER_SAT_EN
      // Carry and overflow stay raw; only the sum is clamped.
      assign sum_load = (!sub_in && slice[CHUNK]) ? '1 :
                        (sub_in && !slice[CHUNK]) ? '0 : sum_next;
`else
      assign sum_load = sum_next;
`endif

      always_ff @(posedge clock) begin
        if (reset) overflow_q <= 1'b0;
        else if (adv) overflow_q <= overflow_next;
      end
    end
  end

  assign io_out_valid = g_stage[STAGES-1].valid_q;
  assign io_sum       = g_stage[STAGES-1].sum_q;
  assign io_carry_out = g_stage[STAGES-1].carry_q;
  assign io_overflow  = g_stage[STAGES-1].g_last.overflow_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, CHUNK=8): directed vectors plus a queue-based model.
// Honours PIPELINED_ADDER_SAT_EN when the design is built with it.
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int STAGES = WIDTH / CHUNK;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             io_in_valid = 1'b0;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_a = '0;
  logic [WIDTH-1:0] io_in_b = '0;
  logic             io_carry_in = 1'b0;
  logic             io_sub = 1'b0;
  logic             io_out_valid;
  logic             io_out_ready = 1'b1;
  logic [WIDTH-1:0] io_sum;
  logic             io_carry_out;
  logic             io_overflow;

  int checks = 0;
  int errors = 0;

  // Model state: expected {overflow, carry, sum} per accepted beat and its age in pipeline advances.
  logic [WIDTH+1:0] exp_q[$];
  int               age_q[$];
  logic             reset_at_edge = 1'b0;
  logic             prev_stall = 1'b0;
  logic [WIDTH+1:0] prev_out = '0;

  pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_a     (io_in_a),
    .io_in_b     (io_in_b),
    .io_carry_in (io_carry_in),
    .io_sub      (io_sub),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_sum      (io_sum),
    .io_carry_out(io_carry_out),
    .io_overflow (io_overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [WIDTH+1:0] actual, input logic [WIDTH+1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [WIDTH+1:0] predict(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] s;
    logic             ovf;
    bb  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
    s   = r[WIDTH-1:0];
    ovf = (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
`ifdef PIPELINED_ADDER_SAT_EN
    if (!sub && r[WIDTH]) s = '1;
    if (sub && !r[WIDTH]) s = '0;
`endif
    return {ovf, r[WIDTH], s};
  endfunction

  always @(posedge clock) reset_at_edge = reset;

  // One compare process: every negedge, predict the output beat and the handshake from the model.
  always @(negedge clock) begin
    logic exp_valid;
    logic adv;
    if (reset) begin
      if (reset_at_edge) begin
        checkOutput("reset_out_valid", io_out_valid, 0);
        checkOutput("reset_sum", io_sum, 0);
        checkOutput("reset_carry_ovf", {io_overflow, io_carry_out}, 0);
        checkOutput("reset_in_ready", io_in_ready, 1);
      end
      exp_q.delete();
      age_q.delete();
      prev_stall = 1'b0;
    end else begin
      exp_valid = (age_q.size() > 0) && (age_q[0] == STAGES);
      checkOutput("out_valid", io_out_valid, exp_valid);
      if (exp_valid) checkOutput("result", {io_overflow, io_carry_out, io_sum}, exp_q[0]);
      checkOutput("in_ready", io_in_ready, !exp_valid || io_out_ready);
      if (prev_stall) checkOutput("stall_hold", {io_overflow, io_carry_out, io_sum}, prev_out);
      prev_stall = io_out_valid && !io_out_ready;
      prev_out   = {io_overflow, io_carry_out, io_sum};
      adv = !exp_valid || io_out_ready;
      if (adv) begin
        if (exp_valid) begin
          void'(exp_q.pop_front());
          void'(age_q.pop_front());
        end
        foreach (age_q[i]) age_q[i] = age_q[i] + 1;
        if (io_in_valid) begin
          exp_q.push_back(predict(io_in_a, io_in_b, io_carry_in, io_sub));
          age_q.push_back(1);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sub);
    @(posedge clock); #1;
    io_in_valid  = 1'b1;
    io_in_a      = a;
    io_in_b      = b;
    io_carry_in  = cin;
    io_sub       = sub;
    io_out_ready = 1'b1;
    @(negedge clock);
    checkOutput("accept_ready", io_in_ready, 1);
    @(posedge clock); #1;
    io_in_valid = 1'b0;
  endtask

  task automatic expectResult(input string name, input logic [WIDTH-1:0] exp_sum,
                              input logic exp_c, input logic exp_o);
    int lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      lat++;
      if (io_out_valid === 1'b1) break;
    end
    checkOutput({name, "_latency"}, lat, STAGES);
    checkOutput({name, "_sum"}, io_sum, exp_sum);
    checkOutput({name, "_carry"}, io_carry_out, exp_c);
    checkOutput({name, "_ovf"}, io_overflow, exp_o);
  endtask

  initial begin
    logic [3:0] pat;
    int         sent;
    int         guard;
    logic       acc;
    pat = 4'b1001;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    expectResult("add_ff_1", 32'h0000_0100, 1'b0, 1'b0);

    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
`ifdef PIPELINED_ADDER_SAT_EN
    expectResult("add_wrap_cin", 32'hFFFF_FFFF, 1'b1, 1'b0);
`else
    expectResult("add_wrap_cin", 32'h0000_0000, 1'b1, 1'b0);
`endif

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
`ifdef PIPELINED_ADDER_SAT_EN
    expectResult("add_ones", 32'hFFFF_FFFF, 1'b1, 1'b0);
`else
    expectResult("add_ones", 32'hFFFF_FFFE, 1'b1, 1'b0);
`endif

    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    expectResult("sub_min_1", 32'h7FFF_FFFF, 1'b1, 1'b1);

    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
`ifdef PIPELINED_ADDER_SAT_EN
    expectResult("sub_5_7", 32'h0000_0000, 1'b0, 1'b0);
`else
    expectResult("sub_5_7", 32'hFFFF_FFFE, 1'b0, 1'b0);
`endif

    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    expectResult("add_ovf", 32'h8000_0000, 1'b0, 1'b1);

    // Back-to-back random beats with the consumer stalling in a 1-0-0-1 pattern.
    sent  = 0;
    guard = 0;
    @(posedge clock); #1;
    io_in_valid  = 1'b1;
    io_in_a      = $urandom;
    io_in_b      = $urandom;
    io_carry_in  = 1'($urandom_range(0, 1));
    io_sub       = 1'($urandom_range(0, 1));
    io_out_ready = pat[0];
    while (sent < 10 && guard < 200) begin
      @(negedge clock);
      acc = io_in_ready;
      @(posedge clock); #1;
      guard++;
      io_out_ready = pat[guard % 4];
      if (acc) begin
        sent++;
        if (sent < 10) begin
          io_in_a     = $urandom;
          io_in_b     = $urandom;
          io_carry_in = 1'($urandom_range(0, 1));
          io_sub      = 1'($urandom_range(0, 1));
        end else begin
          io_in_valid = 1'b0;
        end
      end
    end
    checkOutput("random_sent", sent, 10);
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
    @(negedge clock);
    checkOutput("random_drained", exp_q.size(), 0);

    // Reset with three beats in flight; none of them may emerge.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      io_in_valid = 1'b1;
      io_in_a     = 32'h1000_0000 * (i + 1);
      io_in_b     = 32'h0000_0011;
      io_carry_in = 1'b0;
      io_sub      = 1'b0;
    end
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    reset       = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (6) @(posedge clock);

    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    expectResult("post_reset", 32'h0123_4567, 1'b1, 1'b0);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the team's single-cycle 16-bit adder generator. Adds or subtracts two WIDTH-bit operands in CHUNK-bit slices, one slice per pipeline stage, with carry rippling stage-to-stage, behind a ready/valid handshake with backpressure. It serves datapath blocks whose width makes a single-cycle ripple carry miss timing.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of CHUNK.
- CHUNK, 8: bits added per stage; STAGES = WIDTH/CHUNK (≥1).

- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- io_in_valid  input  1  operand beat offered.
- io_in_ready  output  1  block accepts beat this cycle.
- io_in_a  input  WIDTH  operand A (unsigned / two's complement).
- io_in_b  input  WIDTH  operand B.
- io_carry_in  input  1  carry into bit 0 (add mode only).
- io_sub  input  1  0 = A+B+carry_in, 1 = A−B.
- io_out_valid  output  1  result beat present.
- io_out_ready  input  1  consumer takes result.
- io_sum  output  WIDTH  result bits [WIDTH-1:0].
- io_carry_out  output  1  carry out of MSB (sub: 1 = no borrow).
- io_overflow  output  1  signed overflow of the operation.

## Operation
- Add: result = A + B + carry_in, computed at WIDTH+1 bits; io_sum = low WIDTH bits, io_carry_out = bit WIDTH.
- Sub: result = A + ~B + 1; io_carry_in ignored.
- io_overflow = (a_msb == b'_msb) && (sum_msb != a_msb), b' = B or ~B per mode.
- Stage k (0..STAGES-1) adds slice k of A and b' plus carry from stage k−1 (stage 0: carry_in or 1). Upper slices are skew-delayed so each slice meets its carry; lower result slices are delayed to align at the output.
- Global advance: adv = !io_out_valid || io_out_ready. io_in_ready = adv. All stage registers, including per-stage valid bits, load only when adv; otherwise hold.
- Beat accepted when io_in_valid && io_in_ready. Bubbles propagate as valid=0 stages.
- io_out_valid = valid of last stage; output data stable while io_out_valid && !io_out_ready.

## Timing
- Latency STAGES cycles: beat accepted at edge n appears with io_out_valid=1 after edge n+STAGES−1... precisely, visible in the cycle following edge n+STAGES−1 (STAGES register stages, output registered).
- Throughput one beat/cycle with io_out_ready held high.
- Stall: io_out_ready=0 with io_out_valid=1 freezes whole pipeline and drops io_in_ready same cycle (combinational from io_out_valid/io_out_ready).
- Simultaneous accept and emit with adv=1: both occur; no beat lost or duplicated.
- Reset: all stage valids, io_out_valid, io_sum, io_carry_out, io_overflow = 0 on the first edge with reset=1; in-flight beats discarded; io_in_ready=1 during and after reset.
- STAGES=1: degenerates to a registered full adder, latency 1.
- Operand wrap: A=B=all-ones add gives io_sum=all-ones−1 (carry_in=0), carry_out=1; no other wrap handling.

## Configuration
- PIPELINED_ADDER_SAT_EN defined: unsigned saturation applied at the final stage — add with carry_out=1 forces io_sum to all-ones; sub with carry_out=0 (borrow) forces io_sum to 0. io_carry_out and io_overflow still report raw, unsaturated values.
- Not defined: io_sum is the modular result; no saturation logic instantiated.

## Test plan
- WIDTH=32, CHUNK=8: reset held 3 cycles -> io_out_valid=0, io_sum=0, io_in_ready=1 throughout.
- Add 0x0000_00FF + 0x0000_0001, carry_in=0, ready high -> after 4 cycles io_sum=0x0000_0100, carry_out=0, overflow=0 (carry crosses slice boundary).
- Add 0xFFFF_FFFF + 0x0000_0000, carry_in=1 -> io_sum=0 (sat off) / 0xFFFF_FFFF (PIPELINED_ADDER_SAT_EN), carry_out=1.
- Sub 0x8000_0000 − 0x0000_0001 -> io_sum=0x7FFF_FFFF, carry_out=1, overflow=1; sub 5−7 -> 0xFFFF_FFFE (sat off) / 0 (sat on), carry_out=0.
- Back-to-back 10 random beats, io_out_ready toggled 1-0-0-1 pattern -> results in order, none lost/duplicated, outputs stable while stalled, io_in_ready low whenever out_valid && !out_ready.
- Reset asserted with 3 beats in flight -> no io_out_valid afterward until new beats enter; first new beat emerges after exactly 4 cycles.
